// File: rtl/hive_rbus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hive_rbus_bridge_pkg
// Description : Shared widths and sequencer state type for the register-bus
//               bridge between the core's register-access stage and its
//               peripheral targets.
// Revision    : 1.0  initial release
// ============================================================================
package hive_rbus_bridge_pkg;

  // Core datapath width and register-bus address width
  localparam int ALU_W       = 32;
  localparam int RBUS_ADDR_W = 8;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } rbus_st_t;

endpackage
`default_nettype wire

// File: rtl/hive_rbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : hive_rbus_bridge
// Description : Multi-channel register-bus bridge. Accepts one read and/or
//               write from the core, decodes the upper address bits to a
//               channel, issues a one-cycle strobe, waits for that channel's
//               ack (with timeout) and returns read data with valid/error.
// Revision    : 1.0  initial release
// ============================================================================
module hive_rbus_bridge #(
  parameter int               ALU_W    = hive_rbus_bridge_pkg::ALU_W,
  parameter int               ADDR_W   = hive_rbus_bridge_pkg::RBUS_ADDR_W,
  parameter int               CH_N     = 4,
  parameter int               CH_W     = 2,
  parameter int               TMO_W    = 4,
  parameter logic [ALU_W-1:0] TMO_DATA = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   imda_i,
  input  logic [ALU_W-1:0]       im_alu_i,
  input  logic [ALU_W-1:0]       a_i,
  input  logic [ALU_W-1:0]       b_i,
  input  logic                   reg_rd_i,
  input  logic                   reg_wr_i,
  output logic                   stall_o,
  output logic [ALU_W-1:0]       rd_data_o,
  output logic                   rd_vld_o,
  output logic                   err_o,
  output logic [CH_N-1:0]        ch_rd_o,
  output logic [CH_N-1:0]        ch_wr_o,
  output logic [ADDR_W-CH_W-1:0] ch_addr_o,
  output logic [ALU_W-1:0]       ch_wr_data_o,
  input  logic [CH_N*ALU_W-1:0]  ch_rd_data_i,
  input  logic [CH_N-1:0]        ch_ack_i
);

  import hive_rbus_bridge_pkg::*;

  localparam int SEL_LO = ADDR_W - CH_W;

  rbus_st_t              state_q, state_d;
  logic [CH_W-1:0]       sel_q, sel_d;
  logic                  rd_q, rd_d;
  logic [TMO_W-1:0]      cnt_q, cnt_d;
  logic                  stall_q, stall_d;
  logic [ALU_W-1:0]      rd_data_q, rd_data_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  err_q, err_d;
  logic [CH_N-1:0]       ch_rd_q, ch_rd_d;
  logic [CH_N-1:0]       ch_wr_q, ch_wr_d;
  logic [SEL_LO-1:0]     ch_addr_q, ch_addr_d;
  logic [ALU_W-1:0]      ch_wr_data_q, ch_wr_data_d;

  logic [ADDR_W-1:0]     req_addr;
  logic [CH_W-1:0]       req_sel;
  logic                  req_sel_ok;
  logic                  sel_ok;
  logic                  ack_sel;
  logic [ALU_W-1:0]      ch_data_sel;
  logic [TMO_W-1:0]      cnt_inc;
  logic                  fin;
  logic                  fin_err;
  logic                  unused_addr_bits;

  // Only the low ADDR_W bits of either address source reach the bus
  assign unused_addr_bits = ^{im_alu_i[ALU_W-1:ADDR_W], b_i[ALU_W-1:ADDR_W]};

  assign req_addr    = imda_i ? im_alu_i[ADDR_W-1:0] : b_i[ADDR_W-1:0];
  assign req_sel     = req_addr[ADDR_W-1 -: CH_W];
  assign req_sel_ok  = (int'(req_sel) < CH_N);
  assign sel_ok      = (int'(sel_q) < CH_N);
  // Acks from channels other than the latched one never qualify
  assign ack_sel     = sel_ok && ch_ack_i[sel_q];
  assign ch_data_sel = ch_rd_data_i[int'(sel_q)*ALU_W +: ALU_W];
  assign cnt_inc     = cnt_q + TMO_W'(1);

  // Next state and next registered outputs of the transaction sequencer
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    ch_addr_d    = ch_addr_q;
    ch_wr_data_d = ch_wr_data_q;
    rd_data_d    = rd_data_q;
    ch_rd_d      = '0;
    ch_wr_d      = '0;
    rd_vld_d     = 1'b0;
    err_d        = 1'b0;
    fin          = 1'b0;
    fin_err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reg_rd_i || reg_wr_i) begin
          sel_d        = req_sel;
          rd_d         = reg_rd_i;
          ch_addr_d    = req_addr[SEL_LO-1:0];
          ch_wr_data_d = a_i;
          // Strobes are registered here so they appear during REQ
          if (req_sel_ok) begin
            ch_rd_d[req_sel] = reg_rd_i;
            ch_wr_d[req_sel] = reg_wr_i;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (!sel_ok) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (ack_sel) begin
          fin = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // An ack in the final wait cycle still wins over the timeout
        if (ack_sel) begin
          fin = 1'b1;
        end else if (cnt_inc == '1) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d  = DONE;
      rd_vld_d = rd_q;
      err_d    = fin_err;
      if (rd_q) begin
        rd_data_d = fin_err ? TMO_DATA : ch_data_sel;
      end
    end
    stall_d = (state_d != IDLE);
  end

  // State, timer and all outputs are registered; reset drops any transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      rd_q         <= 1'b0;
      cnt_q        <= '0;
      stall_q      <= 1'b0;
      rd_data_q    <= '0;
      rd_vld_q     <= 1'b0;
      err_q        <= 1'b0;
      ch_rd_q      <= '0;
      ch_wr_q      <= '0;
      ch_addr_q    <= '0;
      ch_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      stall_q      <= stall_d;
      rd_data_q    <= rd_data_d;
      rd_vld_q     <= rd_vld_d;
      err_q        <= err_d;
      ch_rd_q      <= ch_rd_d;
      ch_wr_q      <= ch_wr_d;
      ch_addr_q    <= ch_addr_d;
      ch_wr_data_q <= ch_wr_data_d;
    end
  end

  assign stall_o      = stall_q;
  assign rd_data_o    = rd_data_q;
  assign rd_vld_o     = rd_vld_q;
  assign err_o        = err_q;
  assign ch_rd_o      = ch_rd_q;
  assign ch_wr_o      = ch_wr_q;
  assign ch_addr_o    = ch_addr_q;
  assign ch_wr_data_o = ch_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_hive_rbus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_hive_rbus_bridge
// Description : Bench for hive_rbus_bridge. A transaction-level reference
//               model tracks the main instance every cycle; directed
//               sequences with literal expectations pin the model, and a
//               second instance with three channels covers decode errors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hive_rbus_bridge;

  localparam int TMO_LIMIT = 15;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_i;
  logic         imda_i, reg_rd_i, reg_wr_i;
  logic [31:0]  im_alu_i, a_i, b_i;
  logic         stall_o, rd_vld_o, err_o;
  logic [31:0]  rd_data_o, ch_wr_data_o;
  logic [3:0]   ch_rd_o, ch_wr_o, ch_ack_i;
  logic [5:0]   ch_addr_o;
  logic [127:0] ch_rd_data_i;

  logic         d2_imda, d2_rd, d2_wr;
  logic [31:0]  d2_im, d2_a, d2_b;
  logic         d2_stall, d2_vld, d2_err;
  logic [31:0]  d2_rd_data, d2_ch_wdata;
  logic [2:0]   d2_ch_rd, d2_ch_wr, d2_ack;
  logic [5:0]   d2_ch_addr;
  logic [95:0]  d2_ch_rd_data;

  hive_rbus_bridge u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .imda_i(imda_i), .im_alu_i(im_alu_i),
    .a_i(a_i), .b_i(b_i), .reg_rd_i(reg_rd_i), .reg_wr_i(reg_wr_i),
    .stall_o(stall_o), .rd_data_o(rd_data_o), .rd_vld_o(rd_vld_o),
    .err_o(err_o), .ch_rd_o(ch_rd_o), .ch_wr_o(ch_wr_o),
    .ch_addr_o(ch_addr_o), .ch_wr_data_o(ch_wr_data_o),
    .ch_rd_data_i(ch_rd_data_i), .ch_ack_i(ch_ack_i)
  );

  hive_rbus_bridge #(.CH_N(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .imda_i(d2_imda), .im_alu_i(d2_im),
    .a_i(d2_a), .b_i(d2_b), .reg_rd_i(d2_rd), .reg_wr_i(d2_wr),
    .stall_o(d2_stall), .rd_data_o(d2_rd_data), .rd_vld_o(d2_vld),
    .err_o(d2_err), .ch_rd_o(d2_ch_rd), .ch_wr_o(d2_ch_wr),
    .ch_addr_o(d2_ch_addr), .ch_wr_data_o(d2_ch_wdata),
    .ch_rd_data_i(d2_ch_rd_data), .ch_ack_i(d2_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- reference model of the main instance ----------------
  // Transaction view: after acceptance the bridge is busy; "waited" counts
  // cycles since the strobe. It finishes on the selected ack or when
  // waited reaches TMO_LIMIT, reports in the following cycle, then frees.
  bit          m_busy = 0, m_done = 0, m_rd = 0;
  int          m_sel = 0, m_waited = 0;
  logic        e_stall = 0, e_vld = 0, e_err = 0;
  logic [3:0]  e_rd = '0, e_wr = '0;
  logic [31:0] e_rdata = '0, e_wdata = '0;
  logic [5:0]  e_addr = '0;

  initial begin : p_model
    logic [7:0]  addr;
    logic [31:0] data;
    bit          fin, ferr;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        m_busy = 0; m_done = 0; m_rd = 0; m_waited = 0;
        e_stall = 0; e_vld = 0; e_err = 0; e_rd = '0; e_wr = '0;
        e_rdata = '0; e_wdata = '0; e_addr = '0;
      end
      cmp("m_stall", 64'(stall_o), 64'(e_stall));
      cmp("m_ch_rd", 64'(ch_rd_o), 64'(e_rd));
      cmp("m_ch_wr", 64'(ch_wr_o), 64'(e_wr));
      cmp("m_rd_vld", 64'(rd_vld_o), 64'(e_vld));
      cmp("m_err", 64'(err_o), 64'(e_err));
      cmp("m_rd_data", 64'(rd_data_o), 64'(e_rdata));
      if (e_stall) begin
        cmp("m_ch_addr", 64'(ch_addr_o), 64'(e_addr));
        cmp("m_ch_wdata", 64'(ch_wr_data_o), 64'(e_wdata));
      end
      if (!rst_i) begin
        e_rd = '0; e_wr = '0; e_vld = 0; e_err = 0;
        if (!m_busy) begin
          if (reg_rd_i || reg_wr_i) begin
            addr     = imda_i ? im_alu_i[7:0] : b_i[7:0];
            m_sel    = int'(addr[7:6]);
            m_rd     = reg_rd_i;
            m_busy   = 1;
            m_done   = 0;
            m_waited = 0;
            e_addr   = addr[5:0];
            e_wdata  = a_i;
            e_rd[m_sel] = reg_rd_i;
            e_wr[m_sel] = reg_wr_i;
          end
        end else if (m_done) begin
          m_busy = 0;
        end else begin
          fin = 0; ferr = 0; data = 32'h0;
          if (ch_ack_i[m_sel]) begin
            fin  = 1;
            data = ch_rd_data_i[m_sel*32 +: 32];
          end else if (m_waited + 1 == TMO_LIMIT + 1) begin
            fin  = 1;
            ferr = 1;
          end else begin
            m_waited++;
          end
          if (fin) begin
            m_done = 1;
            e_vld  = m_rd;
            e_err  = ferr;
            if (m_rd) e_rdata = data;
          end
        end
        e_stall = m_busy;
      end
    end
  end

  // ---------------- stimulus with literal expectations ----------------
  initial begin : p_stim
    int mode;
    rst_i = 1'b1;
    imda_i = 0; reg_rd_i = 0; reg_wr_i = 0;
    im_alu_i = '0; a_i = '0; b_i = '0; ch_ack_i = '0; ch_rd_data_i = '0;
    d2_imda = 0; d2_rd = 0; d2_wr = 0; d2_im = '0; d2_a = '0; d2_b = '0;
    d2_ack = '0; d2_ch_rd_data = '0;

    // Reset values
    @(negedge clk_i);
    cmp("rst_stall", 64'(stall_o), 64'd0);
    cmp("rst_ch_addr", 64'(ch_addr_o), 64'd0);
    cmp("rst_ch_wdata", 64'(ch_wr_data_o), 64'd0);
    cmp("rst_rd_data", 64'(rd_data_o), 64'd0);
    cmp("rst_d2_stall", 64'(d2_stall), 64'd0);
    step(); rst_i = 1'b0;
    step();

    // Zero-wait read to channel 1
    imda_i = 1; im_alu_i = 32'h41; b_i = 32'hFF; reg_rd_i = 1;
    @(negedge clk_i); cmp("zw_stall_n", 64'(stall_o), 64'd0);
    step(); reg_rd_i = 0; ch_ack_i = 4'b0010;
    ch_rd_data_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
    @(negedge clk_i);
    cmp("zw_ch_rd", 64'(ch_rd_o), 64'h2);
    cmp("zw_ch_addr", 64'(ch_addr_o), 64'h1);
    cmp("zw_stall_n1", 64'(stall_o), 64'd1);
    step(); ch_ack_i = '0;
    @(negedge clk_i);
    cmp("zw_rd_vld", 64'(rd_vld_o), 64'd1);
    cmp("zw_rd_data", 64'(rd_data_o), 64'hDEAD_BEEF);
    cmp("zw_ch_rd_off", 64'(ch_rd_o), 64'h0);
    step();
    @(negedge clk_i); cmp("zw_stall_n3", 64'(stall_o), 64'd0);

    // Write to channel 3 acked three cycles after the strobe
    step(); imda_i = 0; b_i = 32'hC3; im_alu_i = 32'h0; a_i = 32'h1234; reg_wr_i = 1;
    step(); reg_wr_i = 0; a_i = 32'hFFFF;
    @(negedge clk_i);
    cmp("ww_ch_wr", 64'(ch_wr_o), 64'h8);
    cmp("ww_ch_addr", 64'(ch_addr_o), 64'h3);
    step(); ch_ack_i = 4'b0001;
    @(negedge clk_i);
    cmp("ww_ch_wr_off", 64'(ch_wr_o), 64'h0);
    cmp("ww_wdata_n2", 64'(ch_wr_data_o), 64'h1234);
    step(); ch_ack_i = '0;
    step(); ch_ack_i = 4'b1000;
    @(negedge clk_i); cmp("ww_stall_n4", 64'(stall_o), 64'd1);
    step(); ch_ack_i = '0;
    @(negedge clk_i);
    cmp("ww_rd_vld", 64'(rd_vld_o), 64'd0);
    cmp("ww_stall_n5", 64'(stall_o), 64'd1);
    cmp("ww_wdata_n5", 64'(ch_wr_data_o), 64'h1234);
    step();
    @(negedge clk_i); cmp("ww_stall_n6", 64'(stall_o), 64'd0);

    // Read to channel 2 that never acks
    step(); imda_i = 1; im_alu_i = 32'h85; reg_rd_i = 1;
    step(); reg_rd_i = 0;
    @(negedge clk_i); cmp("to_ch_rd", 64'(ch_rd_o), 64'h4);
    repeat (15) step();
    @(negedge clk_i); cmp("to_vld_early", 64'(rd_vld_o), 64'd0);
    step();
    @(negedge clk_i);
    cmp("to_rd_vld", 64'(rd_vld_o), 64'd1);
    cmp("to_err", 64'(err_o), 64'd1);
    cmp("to_rd_data", 64'(rd_data_o), 64'h0);
    step();

    // Busy: held request ignored, spurious ch0 ack ignored
    step(); im_alu_i = 32'h45; reg_rd_i = 1;
    step(); im_alu_i = 32'h8A; ch_ack_i = 4'b0001;
    @(negedge clk_i); cmp("bz_ch_rd", 64'(ch_rd_o), 64'h2);
    step();
    @(negedge clk_i);
    cmp("bz_no_strobe", 64'(ch_rd_o), 64'h0);
    cmp("bz_ch_addr", 64'(ch_addr_o), 64'h5);
    step(); ch_ack_i = 4'b0010; ch_rd_data_i[63:32] = 32'hCAFE_F00D;
    step(); ch_ack_i = '0; reg_rd_i = 0;
    @(negedge clk_i);
    cmp("bz_rd_vld", 64'(rd_vld_o), 64'd1);
    cmp("bz_rd_data", 64'(rd_data_o), 64'hCAFE_F00D);
    step();
    @(negedge clk_i); cmp("bz_idle", 64'(stall_o), 64'd0);

    // Reset while waiting on channel 3
    step(); im_alu_i = 32'hC7; reg_rd_i = 1;
    step(); reg_rd_i = 0;
    step();
    step(); rst_i = 1'b1;
    @(negedge clk_i);
    cmp("rs_ch_rd", 64'(ch_rd_o), 64'h0);
    cmp("rs_stall", 64'(stall_o), 64'd0);
    step(); rst_i = 1'b0; ch_ack_i = 4'b1000;
    @(negedge clk_i); cmp("rs_no_vld", 64'(rd_vld_o), 64'd0);
    step(); ch_ack_i = '0;
    @(negedge clk_i); cmp("rs_no_vld2", 64'(rd_vld_o), 64'd0);

    // Three-channel instance: good read, then decode error on channel 3
    step(); d2_imda = 1; d2_im = 32'h02; d2_rd = 1;
    step(); d2_rd = 0; d2_ack = 3'b001; d2_ch_rd_data[31:0] = 32'h0BAD_F00D;
    @(negedge clk_i); cmp("de_ch_rd_ok", 64'(d2_ch_rd), 64'h1);
    step(); d2_ack = '0;
    @(negedge clk_i); cmp("de_rd_data_ok", 64'(d2_rd_data), 64'h0BAD_F00D);
    step(); d2_im = 32'hC0; d2_rd = 1; d2_ack = 3'b111;
    step(); d2_rd = 0;
    @(negedge clk_i);
    cmp("de_no_strobe", 64'({d2_ch_rd, d2_ch_wr}), 64'h0);
    cmp("de_err_early", 64'(d2_err), 64'd0);
    step();
    @(negedge clk_i);
    cmp("de_err", 64'(d2_err), 64'd1);
    cmp("de_rd_vld", 64'(d2_vld), 64'd1);
    cmp("de_rd_data", 64'(d2_rd_data), 64'h0);
    step(); d2_ack = '0;
    @(negedge clk_i); cmp("de_idle", 64'(d2_stall), 64'd0);

    // Randomized traffic against the model
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c % 250 == 0) mode = int'($urandom_range(0, 2));
      rst_i    = ($urandom_range(0, 599) == 0);
      reg_rd_i = ($urandom_range(0, 3) == 0);
      reg_wr_i = ($urandom_range(0, 3) == 0);
      imda_i   = 1'($urandom_range(0, 1));
      im_alu_i = $urandom;
      b_i      = $urandom;
      a_i      = $urandom;
      for (int k = 0; k < 4; k++) ch_rd_data_i[k*32 +: 32] = $urandom;
      case (mode)
        0:       ch_ack_i = 4'($urandom);
        1:       for (int k = 0; k < 4; k++) ch_ack_i[k] = ($urandom_range(0, 7) == 0);
        default: ch_ack_i = '0;
      endcase
    end
    step(); rst_i = 0; reg_rd_i = 0; reg_wr_i = 0; ch_ack_i = '0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
